// File: rtl/rv32i_core_pkg.sv
// Shared core types for the register-file write-back path: the write request
// record, the starvation counter width and a one-hot helper for pending masks.
package rv32i_core_pkg;

  localparam int WB_STARVE_W = 4;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } wb_req_t;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    rd_onehot = 32'b1 << rd;
  endfunction

endpackage

// File: rtl/rv32i_wb_arbiter_if.sv
// Bus bundle of the write-back arbiter: pipeline WB request, long-latency
// result handshake, register-file write port, stall and pending-rd status.
interface rv32i_wb_arbiter_if #(
  parameter int LL_DEPTH = 2
);

  logic                        pipe_we_i;
  logic [4:0]                  pipe_addr_i;
  logic [31:0]                 pipe_wdata_i;
  logic                        ll_valid_i;
  logic                        ll_ready_o;
  logic [4:0]                  ll_rd_i;
  logic [31:0]                 ll_wdata_i;
  logic                        rf_we_o;
  logic [4:0]                  rf_waddr_o;
  logic [31:0]                 rf_wdata_o;
  logic                        wb_stall_o;
  logic [31:0]                 ll_pending_mask_o;
  logic [$clog2(LL_DEPTH):0]   ll_count_o;

  // Pipeline / long-latency side: drives requests, observes the write port.
  modport master (
    output pipe_we_i, pipe_addr_i, pipe_wdata_i,
    output ll_valid_i, ll_rd_i, ll_wdata_i,
    input  ll_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    input  wb_stall_o, ll_pending_mask_o, ll_count_o
  );

  // Arbiter side.
  modport slave (
    input  pipe_we_i, pipe_addr_i, pipe_wdata_i,
    input  ll_valid_i, ll_rd_i, ll_wdata_i,
    output ll_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    output wb_stall_o, ll_pending_mask_o, ll_count_o
  );

endinterface

// File: rtl/rv32i_wb_pending_fifo.sv
// Pending FIFO for long-latency write-back results, with an occupancy count
// and a mask of destination registers held by valid entries.
module rv32i_wb_pending_fifo
  import rv32i_core_pkg::*;
#(
  parameter int LL_DEPTH = 2,
  localparam int AW = $clog2(LL_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  wb_req_t       push_req_i,
  input  logic          pop_i,
  output wb_req_t       head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [31:0]   mask_o
);

  wb_req_t       mem [LL_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(LL_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; validity comes only from the
  // reset pointers and count, so stale slot contents are never observed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= push_req_i;
  end

  // Walk the occupied slots from the head; ptr arithmetic wraps naturally.
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < LL_DEPTH; i++) begin
      if (CW'(i) < count_q) mask_o = mask_o | rd_onehot(mem[rd_ptr_q + AW'(i)].rd);
    end
    mask_o[0] = 1'b0;
  end

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, buffered MUL/DIV
// results win after STARVE_LIMIT losses. Optional same-cycle bypass: RV32I_WB_LL_BYPASS_EN.
module rv32i_wb_arbiter
  import rv32i_core_pkg::*;
#(
  parameter int LL_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  rv32i_wb_arbiter_if.slave  bus
);

  localparam int CW = $clog2(LL_DEPTH) + 1;

  wb_req_t                fifo_head;
  wb_req_t                push_req;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [31:0]            fifo_mask;
  logic                   fifo_push;
  logic                   head_grant;
  logic                   bypass;
  logic                   force_grant;
  logic [WB_STARVE_W-1:0] starve_q;

  assign force_grant = (starve_q == WB_STARVE_W'(STARVE_LIMIT));

  // Arbitration: a forced head grant pre-empts the pipe, which is stalled.
  // NOTE: every combinational output gets a default first so no latch forms.
  always_comb begin
    bus.rf_we_o    = 1'b0;
    bus.rf_waddr_o = '0;
    bus.rf_wdata_o = '0;
    bus.wb_stall_o = 1'b0;
    head_grant     = 1'b0;
    bypass         = 1'b0;
    if (force_grant && !fifo_empty) begin
      head_grant     = 1'b1;
      bus.wb_stall_o = bus.pipe_we_i;
    end else if (bus.pipe_we_i) begin
      bus.rf_we_o    = 1'b1;
      bus.rf_waddr_o = bus.pipe_addr_i;
      bus.rf_wdata_o = bus.pipe_wdata_i;
    end else if (!fifo_empty) begin
      head_grant = 1'b1;
`ifdef RV32I_WB_LL_BYPASS_EN
    end else if (bus.ll_valid_i && bus.ll_rd_i != 5'd0) begin
      bypass         = 1'b1;
      bus.rf_we_o    = 1'b1;
      bus.rf_waddr_o = bus.ll_rd_i;
      bus.rf_wdata_o = bus.ll_wdata_i;
`endif
    end
    if (head_grant) begin
      bus.rf_we_o    = fifo_head.we;
      bus.rf_waddr_o = fifo_head.rd;
      bus.rf_wdata_o = fifo_head.wdata;
    end
  end

  // rd==0 results complete the handshake but are never buffered.
  assign bus.ll_ready_o = !fifo_full;
  assign fifo_push      = bus.ll_valid_i && !fifo_full && (bus.ll_rd_i != 5'd0) && !bypass;
  assign push_req       = '{we: 1'b1, rd: bus.ll_rd_i, wdata: bus.ll_wdata_i};

  rv32i_wb_pending_fifo #(
    .LL_DEPTH (LL_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (fifo_push),
    .push_req_i (push_req),
    .pop_i      (head_grant),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .mask_o     (fifo_mask)
  );

  assign bus.ll_count_o        = fifo_count;
  assign bus.ll_pending_mask_o = fifo_mask;

  // NOTE: state registers use non-blocking assignment only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (fifo_empty || head_grant) begin
      starve_q <= '0;
    end else if (!force_grant) begin
      starve_q <= starve_q + 1'b1;
    end
  end

`ifndef SYNTHESIS
  // The issue scoreboard must never let the pipe target a buffered rd.
  a_no_pending_hazard: assert property (
    @(posedge clk_i) disable iff (rst_i)
      bus.pipe_we_i |-> !fifo_mask[bus.pipe_addr_i]
  );
`endif

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Self-checking bench for rv32i_wb_arbiter: directed scenarios plus a randomized
// run checked against a queue-based model of the write-port sharing rules.
module tb_rv32i_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rv32i_wb_arbiter_if #(.LL_DEPTH(DEPTH)) bus ();

  rv32i_wb_arbiter #(
    .LL_DEPTH     (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_we_i    = 1'b0;
    bus.pipe_addr_i  = 5'd0;
    bus.pipe_wdata_i = 32'd0;
    bus.ll_valid_i   = 1'b0;
    bus.ll_rd_i      = 5'd0;
    bus.ll_wdata_i   = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    do_reset();
    #2;
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0b exp 0", bus.rf_we_o); end
    checks++; if (bus.ll_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", bus.ll_ready_o); end
    checks++; if (bus.ll_count_o !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.ll_count_o); end
    checks++; if (bus.ll_pending_mask_o !== 32'd0) begin errors++; $display("FAIL reset_mask got %h exp 0", bus.ll_pending_mask_o); end
    checks++; if (bus.wb_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", bus.wb_stall_o); end
    tick();
  endtask

  // rd=5 enqueued alongside a pipe write; drained the next cycle.
  task automatic test_single();
    idle();
    bus.pipe_we_i = 1'b1; bus.pipe_addr_i = 5'd1; bus.pipe_wdata_i = 32'h1111;
    bus.ll_valid_i = 1'b1; bus.ll_rd_i = 5'd5; bus.ll_wdata_i = 32'hDEAD_BEEF;
    #2;
    checks++; if (bus.ll_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready got %0b exp 1", bus.ll_ready_o); end
    checks++; if (bus.rf_waddr_o !== 5'd1) begin errors++; $display("FAIL single_pipe_addr got %0d exp 1", bus.rf_waddr_o); end
    tick();
    idle();
    #2;
    checks++; if (bus.rf_we_o !== 1'b1) begin errors++; $display("FAIL single_we got %0b exp 1", bus.rf_we_o); end
    checks++; if (bus.rf_waddr_o !== 5'd5) begin errors++; $display("FAIL single_addr got %0d exp 5", bus.rf_waddr_o); end
    checks++; if (bus.rf_wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", bus.rf_wdata_o); end
    checks++; if (bus.ll_pending_mask_o !== 32'h0000_0020) begin errors++; $display("FAIL single_mask_set got %h exp 00000020", bus.ll_pending_mask_o); end
    tick();
    #2;
    checks++; if (bus.ll_pending_mask_o !== 32'd0) begin errors++; $display("FAIL single_mask_clr got %h exp 0", bus.ll_pending_mask_o); end
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL single_idle_we got %0b exp 0", bus.rf_we_o); end
    checks++; if (bus.ll_count_o !== 2'd0) begin errors++; $display("FAIL single_count got %0d exp 0", bus.ll_count_o); end
    tick();
  endtask

  // Continuous pipe writes; the buffered rd=7 wins on the fifth cycle.
  task automatic test_starve();
    idle();
    bus.pipe_we_i = 1'b1; bus.pipe_addr_i = 5'd1; bus.pipe_wdata_i = 32'h1000;
    bus.ll_valid_i = 1'b1; bus.ll_rd_i = 5'd7; bus.ll_wdata_i = 32'h0000_0077;
    tick();
    bus.ll_valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      bus.pipe_wdata_i = 32'h1000 + 32'(c);
      #2;
      checks++;
      if (bus.rf_waddr_o !== 5'd1 || bus.rf_wdata_o !== 32'h1000 + 32'(c) || bus.wb_stall_o !== 1'b0)
        begin errors++; $display("FAIL starve_pipe_c%0d got addr %0d data %h stall %0b exp addr 1 data %h stall 0",
                                  c, bus.rf_waddr_o, bus.rf_wdata_o, bus.wb_stall_o, 32'h1000 + 32'(c)); end
      tick();
    end
    bus.pipe_wdata_i = 32'h1005;
    #2;
    checks++; if (bus.rf_waddr_o !== 5'd7 || bus.rf_wdata_o !== 32'h77) begin errors++; $display("FAIL starve_forced got addr %0d data %h exp addr 7 data 77", bus.rf_waddr_o, bus.rf_wdata_o); end
    checks++; if (bus.wb_stall_o !== 1'b1) begin errors++; $display("FAIL starve_stall got %0b exp 1", bus.wb_stall_o); end
    tick();
    #2;
    checks++; if (bus.rf_waddr_o !== 5'd1 || bus.rf_wdata_o !== 32'h1005 || bus.wb_stall_o !== 1'b0) begin errors++; $display("FAIL starve_retry got addr %0d data %h stall %0b exp addr 1 data 1005 stall 0", bus.rf_waddr_o, bus.rf_wdata_o, bus.wb_stall_o); end
    tick();
    idle();
  endtask

  // Fill with rd=3/4, hold a third result until a pop frees space.
  task automatic test_full();
    idle();
    bus.pipe_we_i = 1'b1; bus.pipe_addr_i = 5'd1;
    bus.ll_valid_i = 1'b1; bus.ll_rd_i = 5'd3; bus.ll_wdata_i = 32'h33;
    tick();
    bus.ll_rd_i = 5'd4; bus.ll_wdata_i = 32'h44;
    tick();
    bus.ll_rd_i = 5'd10; bus.ll_wdata_i = 32'hAA;
    #2;
    checks++; if (bus.ll_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", bus.ll_ready_o); end
    checks++; if (bus.ll_count_o !== 2'd2) begin errors++; $display("FAIL full_count got %0d exp 2", bus.ll_count_o); end
    checks++; if (bus.ll_pending_mask_o !== 32'h0000_0018) begin errors++; $display("FAIL full_mask got %h exp 00000018", bus.ll_pending_mask_o); end
    tick();
    bus.pipe_we_i = 1'b0;
    #2;
    checks++; if (bus.rf_waddr_o !== 5'd3 || bus.ll_ready_o !== 1'b0) begin errors++; $display("FAIL full_pop_head got addr %0d ready %0b exp addr 3 ready 0", bus.rf_waddr_o, bus.ll_ready_o); end
    tick();
    #2;
    checks++; if (bus.rf_waddr_o !== 5'd4 || bus.ll_ready_o !== 1'b1) begin errors++; $display("FAIL full_accept got addr %0d ready %0b exp addr 4 ready 1", bus.rf_waddr_o, bus.ll_ready_o); end
    tick();
    idle();
    #2;
    checks++; if (bus.ll_count_o !== 2'd1) begin errors++; $display("FAIL full_swap_count got %0d exp 1", bus.ll_count_o); end
    checks++; if (bus.ll_pending_mask_o !== 32'h0000_0400) begin errors++; $display("FAIL full_swap_mask got %h exp 00000400", bus.ll_pending_mask_o); end
    checks++; if (bus.rf_waddr_o !== 5'd10 || bus.rf_wdata_o !== 32'hAA) begin errors++; $display("FAIL full_third got addr %0d data %h exp addr 10 data aa", bus.rf_waddr_o, bus.rf_wdata_o); end
    tick();
    #2;
    checks++; if (bus.ll_count_o !== 2'd0) begin errors++; $display("FAIL full_drained got %0d exp 0", bus.ll_count_o); end
  endtask

  task automatic test_rd0();
    idle();
    bus.ll_valid_i = 1'b1; bus.ll_rd_i = 5'd0; bus.ll_wdata_i = 32'h1234;
    #2;
    checks++; if (bus.ll_ready_o !== 1'b1) begin errors++; $display("FAIL rd0_ready got %0b exp 1", bus.ll_ready_o); end
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL rd0_same_we got %0b exp 0", bus.rf_we_o); end
    tick();
    idle();
    #2;
    checks++; if (bus.ll_count_o !== 2'd0) begin errors++; $display("FAIL rd0_count got %0d exp 0", bus.ll_count_o); end
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL rd0_we got %0b exp 0", bus.rf_we_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    bus.pipe_we_i = 1'b1; bus.pipe_addr_i = 5'd1;
    bus.ll_valid_i = 1'b1; bus.ll_rd_i = 5'd11;
    tick();
    bus.ll_rd_i = 5'd12;
    tick();
    idle();
    #2;
    checks++; if (bus.ll_count_o !== 2'd2) begin errors++; $display("FAIL mid_before got %0d exp 2", bus.ll_count_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    checks++; if (bus.ll_count_o !== 2'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", bus.ll_count_o); end
    checks++; if (bus.ll_pending_mask_o !== 32'd0) begin errors++; $display("FAIL mid_mask got %h exp 0", bus.ll_pending_mask_o); end
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL mid_we got %0b exp 0", bus.rf_we_o); end
    checks++; if (bus.ll_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b exp 1", bus.ll_ready_o); end
    tick();
  endtask

  // rd=9 on an empty FIFO with no pipe write.
  task automatic test_bypass();
    idle();
    bus.ll_valid_i = 1'b1; bus.ll_rd_i = 5'd9; bus.ll_wdata_i = 32'h9999;
    #2;
`ifdef RV32I_WB_LL_BYPASS_EN
    checks++; if (bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd9 || bus.rf_wdata_o !== 32'h9999) begin errors++; $display("FAIL bypass_same got we %0b addr %0d data %h exp we 1 addr 9 data 9999", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
    tick();
    idle();
    #2;
    checks++; if (bus.ll_count_o !== 2'd0 || bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL bypass_after got count %0d we %0b exp count 0 we 0", bus.ll_count_o, bus.rf_we_o); end
`else
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL nobypass_same got we %0b exp 0", bus.rf_we_o); end
    tick();
    idle();
    #2;
    checks++; if (bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd9 || bus.rf_wdata_o !== 32'h9999) begin errors++; $display("FAIL nobypass_next got we %0b addr %0d data %h exp we 1 addr 9 data 9999", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
`endif
    tick();
  endtask

  // Random traffic against a queue model of the sharing rules.
  task automatic test_random();
    logic [4:0]  q_rd[$];
    logic [31:0] q_data[$];
    int          lost;
    logic [31:0] m_mask;
    logic        pw, lv, e_we, e_stall, e_ready, take_head, byp, was_empty;
    logic [4:0]  pa, lrd, e_addr;
    logic [31:0] pd, ld, e_data;
    idle();
    do_reset();
    lost = 0;
    for (int n = 0; n < 600; n++) begin
      m_mask = 32'd0;
      foreach (q_rd[k]) m_mask = m_mask | (32'b1 << q_rd[k]);
      pw = ($urandom_range(0, 9) < 6);
      pa = 5'($urandom_range(1, 31));
      for (int t = 0; t < 64 && m_mask[pa]; t++) pa = 5'($urandom_range(1, 31));
      if (m_mask[pa]) pw = 1'b0;
      pd  = $urandom;
      lv  = ($urandom_range(0, 1) == 1);
      lrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ld  = $urandom;
      bus.pipe_we_i = pw; bus.pipe_addr_i = pa; bus.pipe_wdata_i = pd;
      bus.ll_valid_i = lv; bus.ll_rd_i = lrd; bus.ll_wdata_i = ld;

      e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0; e_stall = 1'b0;
      take_head = 1'b0; byp = 1'b0;
      e_ready = (q_rd.size() < DEPTH);
      was_empty = (q_rd.size() == 0);
      if (!was_empty && (lost == LIMIT || !pw)) begin
        take_head = 1'b1; e_we = 1'b1; e_addr = q_rd[0]; e_data = q_data[0]; e_stall = pw;
      end else if (pw) begin
        e_we = 1'b1; e_addr = pa; e_data = pd;
      end
`ifdef RV32I_WB_LL_BYPASS_EN
      else if (lv && lrd != 5'd0) begin
        byp = 1'b1; e_we = 1'b1; e_addr = lrd; e_data = ld;
      end
`endif
      #2;
      checks++; if (bus.rf_we_o !== e_we) begin errors++; $display("FAIL rand_we n=%0d got %0b exp %0b", n, bus.rf_we_o, e_we); end
      if (e_we) begin
        checks++; if (bus.rf_waddr_o !== e_addr || bus.rf_wdata_o !== e_data) begin errors++; $display("FAIL rand_write n=%0d got addr %0d data %h exp addr %0d data %h", n, bus.rf_waddr_o, bus.rf_wdata_o, e_addr, e_data); end
      end
      checks++; if (bus.wb_stall_o !== e_stall) begin errors++; $display("FAIL rand_stall n=%0d got %0b exp %0b", n, bus.wb_stall_o, e_stall); end
      checks++; if (bus.ll_ready_o !== e_ready) begin errors++; $display("FAIL rand_ready n=%0d got %0b exp %0b", n, bus.ll_ready_o, e_ready); end
      checks++; if (int'(bus.ll_count_o) != q_rd.size()) begin errors++; $display("FAIL rand_count n=%0d got %0d exp %0d", n, bus.ll_count_o, q_rd.size()); end
      checks++; if (bus.ll_pending_mask_o !== m_mask) begin errors++; $display("FAIL rand_mask n=%0d got %h exp %h", n, bus.ll_pending_mask_o, m_mask); end

      if (take_head) begin
        void'(q_rd.pop_front());
        void'(q_data.pop_front());
      end
      if (lv && e_ready && lrd != 5'd0 && !byp) begin
        q_rd.push_back(lrd);
        q_data.push_back(ld);
      end
      if (was_empty || take_head) lost = 0;
      else if (lost < LIMIT) lost++;
      tick();
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_single();
    test_starve();
    test_full();
    test_rd0();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_wb_arbiter.md
Name: rv32i_wb_arbiter

Overview:
- Owns the single register-file write port and shares it between two sources: the in-order WB stage output and the long-latency (MUL/DIV) result path.
- Buffers long-latency results in a small pending FIFO.
- Gives the pipeline default priority, with a starvation guard.
- Exports a pending-rd mask so the issue scoreboard can block RAW/WAW hazards against buffered results.

Parameters:
- LL_DEPTH, 2, pending FIFO entries; power of two, >=2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO head may lose before it forces a grant; range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- pipe_we_i  in  1  WB stage write request; already qualified (valid, reg_write, rd!=0)
- pipe_addr_i  in  5  WB stage destination
- pipe_wdata_i  in  32  WB stage data
- ll_valid_i  in  1  long-latency result valid
- ll_ready_o  out  1  FIFO can accept
- ll_rd_i  in  5  long-latency destination
- ll_wdata_i  in  32  long-latency data
- rf_we_o  out  1  regfile write enable
- rf_waddr_o  out  5  regfile write address
- rf_wdata_o  out  32  regfile write data
- wb_stall_o  out  1  hold MEM/WB register this cycle; pipe write is retried next cycle
- ll_pending_mask_o  out  32  bit r set when any FIFO entry targets xr; bit 0 always 0
- ll_count_o  out  $clog2(LL_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_i high at a clock edge):
  - FIFO emptied, pointers 0, starvation counter 0, force flag 0.
  - Next cycle: ll_ready_o=1, ll_count_o=0, ll_pending_mask_o=0, rf_we_o=0, wb_stall_o=0.
  - Reset mid-operation silently discards pending entries.
- Handshake:
  - Enqueue when ll_valid_i && ll_ready_o.
  - ll_ready_o = (count != LL_DEPTH) and is a function of registered count only. No combinational path from ll_valid_i.
  - Entries with ll_rd_i==0 are handshaken but not stored.
  - When full, ll_ready_o=0; no same-cycle enqueue-on-dequeue.
- Latency: a stored entry enqueued in cycle t is writable no earlier than t+1, unless the optional bypass applies.
- Arbitration, evaluated per cycle (rf_* outputs are combinational from registered state and pipe_* inputs):
  - force=0 and pipe_we_i=1: grant pipe; rf_* = pipe_*.
  - pipe_we_i=0 and FIFO non-empty: grant FIFO head and pop.
  - force=1 and FIFO non-empty: grant FIFO head and pop; wb_stall_o = pipe_we_i.
  - Otherwise rf_we_o=0.
- Starvation counter:
  - Increments when the FIFO is non-empty and the head is not granted.
  - Clears on any head grant or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - force = (counter == STARVE_LIMIT). force clears the cycle after the forced grant because the counter returns to 0.
- ll_pending_mask_o is the OR of one-hot(rd) over valid entries, registered and updated with FIFO state.
- Simultaneous enqueue and head pop: count unchanged; mask reflects both changes next cycle.
- Hazard contract: the scoreboard guarantees pipe_addr_i never matches a set ll_pending_mask_o bit while pipe_we_i=1. The RTL carries an assertion for this under simulation.

Optional Feature:
- Macro: RV32I_WB_LL_BYPASS_EN
- Defined: when FIFO empty, pipe_we_i=0 and ll_valid_i=1 with ll_rd_i!=0, the result is written the same cycle (rf_* = ll_*) and not stored. This creates a combinational path ll_valid_i -> rf_we_o.
- Undefined: all long-latency results pass through the FIFO, giving minimum one-cycle latency and no input-to-port combinational path.

Decomposition:
- rv32i_core_pkg gets:
  - typedef wb_req_t {logic we; logic [4:0] rd; logic [31:0] wdata}
  - localparam WB_STARVE_W = 4
- Sub-module rv32i_wb_pending_fifo (LL_DEPTH entries of wb_req_t): push/pop/count/full/empty plus the pending-mask output.
- Arbitration and starvation logic stay in the top module.

Test Plan:
- Reset, then idle: rf_we_o=0, ll_ready_o=1, ll_count_o=0, mask=0.
- ll result rd=5 data=0xDEAD_BEEF in cycle 1, no pipe writes: cycle 2 rf_we_o=1, waddr=5, wdata=0xDEADBEEF. mask bit5 set in cycle 2 only, clear in cycle 3.
- Pipe writes every cycle, ll entry rd=7 enqueued in cycle 0, STARVE_LIMIT=4:
  - Cycles 1-4: pipe granted.
  - Cycle 5: rd=7 written and wb_stall_o=1.
  - Cycle 6: the held pipe write is granted.
- Fill FIFO with rd=3 and rd=4 while pipe writes: ll_ready_o=0 and count=2. Third ll_valid_i is held until a pop, then accepted.
- ll_valid_i with rd=0: accepted with ll_ready_o=1, count stays 0, no regfile write.
- Assert rst_i with 2 entries pending: next cycle count=0, mask=0, rf_we_o=0. With RV32I_WB_LL_BYPASS_EN, rd=9 on an empty FIFO with no pipe write is written in the same cycle.
